// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 key-schedule definitions: word/block/index types, round
// count, round-constant seed and reduction polynomial, the GF(2^8) xtime
// helper and the key-expansion FSM state encoding.
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  typedef logic [3:0]   rk_idx_t;

  // Number of rounds for AES-128; round keys rk[0..NR] are produced.
  localparam rk_idx_t    NR        = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    MIX,
    DONE
  } state_t;

  // Multiply by x in GF(2^8): shift left, fold the carry back with the
  // field polynomial (so 8'h80 -> 8'h1b).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_key_sched_s4.sv
// -----------------------------------------------------------------------------
// aes128_key_sched_s4
// Registered 4-byte AES S-box: applies SubBytes to each byte of a 32-bit word
// and registers the result, giving exactly one cycle of latency.
//
// Ports
//   clk   in   1   rising-edge clock
//   din   in  32   word to substitute ([31:24] is the first byte)
//   dout  out 32   registered substituted word, same byte order
// -----------------------------------------------------------------------------
module aes128_key_sched_s4 (
  input  logic        clk,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // No reset: dout is only consumed in the cycle after it was loaded from a
  // valid input, so its power-up content never matters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation order cannot create races.
    dout <= {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};
  end

endmodule

// File: rtl/aes128_key_sched.sv
// -----------------------------------------------------------------------------
// aes128_key_sched
// Iterative AES-128 key expansion. Accepts one cipher key over valid/ready,
// produces rk[1]..rk[10] at one key per two clocks (SUB: S-box lookup,
// MIX: XOR chain and write-back), stores all 11 round keys and serves them
// through a registered random-access read port.
//
// Ports
//   clk         in    1   rising-edge clock
//   rst         in    1   synchronous active-high reset
//   key_in      in  128   cipher key, [127:96] = w0 ... [31:0] = w3
//   key_valid   in    1   key_in valid this cycle
//   key_ready   out   1   a key can be accepted (combinational from state)
//   rk_idx      in    4   round-key index to read, 0..10 (11..15 read zero)
//   rk_out      out 128   rk[rk_idx] sampled at the previous edge
//   keys_valid  out   1   all 11 round keys valid and stable
//   busy        out   1   expansion in progress (combinational from state)
//
// Configuration
//   AES128_KEY_SCHED_RELOAD_EN  when defined, key_ready is held high and a key
//                               accepted mid-expansion restarts the schedule,
//                               discarding the in-flight one. Undefined: keys
//                               are only accepted in IDLE or DONE.
// -----------------------------------------------------------------------------
module aes128_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         keys_valid,
  output logic         busy
);

  state_t     state;
  rk_idx_t    cnt;     // index of the round key being produced
  logic [7:0] rcon;
  block_t     rk [0:NR];

  rk_idx_t prev_idx;
  block_t  prev_rk;
  word_t   sbox_in;
  word_t   sbox_out;
  word_t   t_word;
  word_t   w4, w5, w6, w7;
  logic    accept;

  assign busy = (state == SUB) || (state == MIX);

`ifdef AES128_KEY_SCHED_RELOAD_EN
  assign key_ready = 1'b1;
`else
  assign key_ready = (state == IDLE) || (state == DONE);
`endif

  assign accept = key_valid && key_ready;

  // Previous round key. In IDLE cnt is 0, so prev_idx wraps to 15; that
  // value is never consumed but is forced to zero to keep the read in range.
  assign prev_idx = cnt - 4'd1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    prev_rk = '0;
    if (prev_idx <= NR) prev_rk = rk[prev_idx];
  end

  // RotWord of w3: one-byte left rotation.
  assign sbox_in = {prev_rk[23:0], prev_rk[31:24]};

  aes128_key_sched_s4 u_s4 (
    .clk  (clk),
    .din  (sbox_in),
    .dout (sbox_out)
  );

  // Word chain of the next round key; sbox_out holds SubWord(RotWord(w3))
  // registered at the end of SUB.
  always_comb begin
    t_word = sbox_out ^ {rcon, 24'h0};
    w4     = prev_rk[127:96] ^ t_word;
    w5     = prev_rk[95:64]  ^ w4;
    w6     = prev_rk[63:32]  ^ w5;
    w7     = prev_rk[31:0]   ^ w6;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rcon       <= RCON_INIT;
      keys_valid <= 1'b0;
      rk_out     <= '0;
      // NOTE: the round-key file is reset because reads are legal at any
      // time and must return zero after reset, not power-up garbage.
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      // Read port samples the pre-edge contents, so a same-edge write to the
      // addressed entry returns the old value.
      rk_out <= (rk_idx <= NR) ? rk[rk_idx] : '0;

      if (accept) begin
        rk[0]      <= key_in;
        rcon       <= RCON_INIT;
        cnt        <= 4'd1;
        keys_valid <= 1'b0;
        state      <= SUB;
      end else begin
        case (state)
          SUB: state <= MIX;
          MIX: begin
            rk[cnt] <= {w4, w5, w6, w7};
            rcon    <= xtime(rcon);
            if (cnt == NR) begin
              state      <= DONE;
              keys_valid <= 1'b1;
            end else begin
              cnt   <= cnt + 4'd1;
              state <= SUB;
            end
          end
          default: ;  // IDLE and DONE hold until a key is accepted
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes128_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes128_key_sched
// Scoreboarded bench for aes128_key_sched. The reference model derives the
// S-box from GF(2^8) inversion plus the affine map and expands keys with the
// word-level FIPS-197 recurrence. Stimulus pushes expected keys_valid rise
// cycles and expected read data into queues; a negedge monitor pops and
// compares whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_aes128_key_sched;

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam int           EXP_LAT    = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         keys_valid;
  logic         busy;

  aes128_key_sched dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           due;
    logic [127:0] exp;
    int           idx;
  } rd_t;

  rd_t  rd_q[$];
  int   exp_done_q[$];
  logic kv_prev = 1'b0;
  rd_t  rd_cur;

  logic [7:0]   sbox_tab [256];
  logic [127:0] model_rk [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      model_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      rd_cur = rd_q.pop_front();
      check($sformatf("rd_idx%0d", rd_cur.idx), rk_out, rd_cur.exp);
    end
    if (keys_valid && !kv_prev) begin
      if (exp_done_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL kv_unexpected: keys_valid rose at cycle %0d, none expected", cyc);
      end else begin
        check("kv_latency", 128'(cyc), 128'(exp_done_q.pop_front()));
      end
    end
    kv_prev = keys_valid;
  end

  // ---------------- stimulus ----------------
  task automatic issue_read(input int idx, input logic [127:0] exp);
    rd_t r;
    rk_idx = idx[3:0];
    r.due  = cyc + 1;
    r.exp  = exp;
    r.idx  = idx;
    rd_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic accept(input logic [127:0] key);
    check("accept_ready", {127'h0, key_ready}, 128'h1);
    key_in    = key;
    key_valid = 1'b1;
    expand(key);
    exp_done_q.push_back(cyc + 1 + EXP_LAT);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_kv();
    int n = 0;
    while (keys_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("kv_rise", {127'h0, keys_valid}, 128'h1);
  endtask

  task automatic read_all_model();
    for (int i = 0; i < 11; i++) issue_read(i, model_rk[i]);
  endtask

  logic [127:0] key2;
  logic [127:0] rkey;

  initial begin
    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rk_idx    = '0;
    build_sbox();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_keys_valid", {127'h0, keys_valid}, 128'h0);
    check("rst_busy",       {127'h0, busy},       128'h0);
    check("rst_key_ready",  {127'h0, key_ready},  128'h1);
    check("rst_rk_out",     rk_out,               128'h0);
    rst = 1'b0;
    issue_read(0, 128'h0);
    issue_read(10, 128'h0);

    // FIPS-197 key, with a second key pulsed mid-expansion
    accept(FIPS_KEY);
    issue_read(0, FIPS_KEY);
    check("exp_busy", {127'h0, busy}, 128'h1);
`ifndef AES128_KEY_SCHED_RELOAD_EN
    check("exp_key_ready", {127'h0, key_ready}, 128'h0);
`endif
    repeat (3) @(negedge clk);
    key2      = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_in    = key2;
    key_valid = 1'b1;
`ifdef AES128_KEY_SCHED_RELOAD_EN
    exp_done_q.delete();
    exp_done_q.push_back(cyc + 1 + EXP_LAT);
    expand(key2);
`endif
    @(negedge clk);
    key_valid = 1'b0;
    check("pulse_keys_valid", {127'h0, keys_valid}, 128'h0);
    check("pulse_busy",       {127'h0, busy},       128'h1);
    wait_kv();
`ifdef AES128_KEY_SCHED_RELOAD_EN
    read_all_model();
`else
    issue_read(1, FIPS_RK1);
    issue_read(10, FIPS_RK10);
    read_all_model();
`endif
    issue_read(11, 128'h0);
    issue_read(15, 128'h0);

    // From DONE, accept the all-zero key
    accept(128'h0);
    check("done_accept_kv_fall", {127'h0, keys_valid}, 128'h0);
    check("done_accept_busy",    {127'h0, busy},       128'h1);
    wait_kv();
    issue_read(1, ZERO_RK1);
    issue_read(10, ZERO_RK10);
    read_all_model();

    // Reset mid-expansion at E9
    rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
    accept(rkey);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    exp_done_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_keys_valid", {127'h0, keys_valid}, 128'h0);
    check("abort_busy",       {127'h0, busy},       128'h0);
    check("abort_key_ready",  {127'h0, key_ready},  128'h1);
    check("abort_rk_out",     rk_out,               128'h0);
    for (int i = 0; i < 16; i++) issue_read(i, 128'h0);
    accept(128'h0);
    wait_kv();
    issue_read(1, ZERO_RK1);
    issue_read(10, ZERO_RK10);

    // Random keys against the model
    for (int k = 0; k < 3; k++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
      accept(rkey);
      wait_kv();
      read_all_model();
      issue_read(11 + int'($urandom_range(4)), 128'h0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 128'(exp_done_q.size()), 128'h0);
    check("reads_drained",      128'(rd_q.size()),       128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_key_sched.md
# aes128_key_sched

Iterative AES-128 key-expansion stage directly upstream of the round datapath. Accepts one 128-bit cipher key over a valid/ready handshake and computes the 11 round keys (rk[0]..rk[10]) at one key per two clocks, matching the two-cycle round cadence. Stores all round keys in an internal register file and serves them through a registered random-access read port. The round controller feeds these to the key inputs of the full rounds (rk[1..9]) and the final round (rk[10]).

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, synchronous, active-high
- key_in  in  128  cipher key; [127:96] is word w0, [31:0] is w3
- key_valid  in  1  key_in is valid this cycle
- key_ready  out  1  block can accept a key; high in IDLE and DONE
- rk_idx  in  4  round-key index to read, 0..10
- rk_out  out  128  registered read data: rk[rk_idx] from the previous cycle; same word order as key_in
- keys_valid  out  1  all 11 round keys are valid and stable
- busy  out  1  expansion in progress

## Operation
- FSM states: IDLE, SUB, MIX, DONE.
- Accept on the rising edge where key_valid && key_ready. At that edge: rk[0] <= key_in, rcon <= 8'h01, cnt <= 1, keys_valid <= 0, state <= SUB.
- SUB: drive the 4-byte S-box with RotWord(w3 of rk[cnt-1]), i.e. {w3[23:0], w3[31:24]}. The S-box output registers at the end of SUB. state <= MIX.
- MIX: t = SBOX_OUT ^ {rcon, 24'h0}. Then w4 = w0^t, w5 = w1^w4, w6 = w2^w5, w7 = w3^w6, all taken from rk[cnt-1].
  - rk[cnt] <= {w4,w5,w6,w7}; rcon <= xtime(rcon), where 8'h80 -> 8'h1b.
  - If cnt == 10: state <= DONE, keys_valid <= 1. Otherwise cnt <= cnt+1 and state <= SUB.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- DONE: keys held until a new key is accepted or rst.
  - Accepting a key in DONE takes the same path as in IDLE. keys_valid falls at the accept edge.
- Read port: every cycle rk_out <= rk[rk_idx] when rk_idx <= 10; rk_idx 11..15 gives 128'h0.
  - Reads are legal in any state. During expansion, entries not yet written hold stale data.
- busy = (state == SUB || state == MIX). key_ready = (state == IDLE || state == DONE); both are combinational from state.

## Timing
- Accept at edge E0 → rk[i] written at edge E(2i) → rk[10] and keys_valid at E20. Expansion latency: 20 cycles.
- Read latency: 1 cycle, rk_idx to rk_out.
- Reset values: state IDLE, rk[0..10] = 0, rk_out = 0, keys_valid = 0, busy = 0, key_ready = 1, cnt = 0, rcon = 8'h01.
- rst overrides every other input on the same edge.
- rst during SUB/MIX aborts the expansion; no partial key set is flagged valid.
- key_valid while busy (without the reload feature): ignored, because key_ready = 0. No stall or loss of the in-flight expansion.
- A write to rk[cnt] and a read of the same index on the same edge: rk_out returns the old value (read before write).

## Configuration
- Macro: AES128_KEY_SCHED_RELOAD_EN.
- Defined: key_ready = 1 in all non-reset states. A key accepted during SUB/MIX restarts expansion at that edge exactly as from IDLE. The in-flight expansion is discarded and keys_valid stays 0.
- Undefined: behaviour as in Operation; key_ready = 0 while busy.

## Structure
- Shared package aes_pkg holds:
  - typedefs: word_t [31:0], block_t [127:0], round-key index type [3:0]
  - constants: NR = 10, RCON_INIT = 8'h01, RCON_POLY = 8'h1b
  - function xtime
  - state enum (IDLE, SUB, MIX, DONE)
- One sub-module instance: the existing registered 4-byte S-box S4 (ports clk, 32-bit in, 32-bit out). Its one-cycle registration defines the SUB stage.
- FSM, rcon register, counter and rk register file live in aes128_key_sched.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, accepted at E0:
  - keys_valid rises at E20.
  - rk[1] = a0fafe1788542cb123a339392a6c7605.
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - rk[1] = 62636363626363636263636362636363.
  - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- Read port:
  - rk_idx = 0 → rk_out equals the accepted key one cycle later.
  - rk_idx = 11 and 15 → 128'h0.
- Pulse key_valid with a second key while busy:
  - RELOAD_EN undefined: ignored; FIPS-197 results unchanged at E20.
  - RELOAD_EN defined: restart; keys_valid 20 cycles after the second accept, with that key's schedule.
- Assert rst at E9 mid-expansion:
  - Next cycle: keys_valid = 0, busy = 0, key_ready = 1, rk_out = 0 for every index.
  - A following zero-key accept produces correct keys.
- From DONE, accept the zero key:
  - keys_valid falls at the accept edge and rises 20 cycles later.
  - rk[10] updates from d014…0ca6 to b4ef…188e.
